// File: rtl/cargador_instrucciones_if.sv
// Byte-in / memory-write bundle for the instruction loader.
// The slave modport is the loader's view; the master modport is the byte source / memory side.
interface cargador_instrucciones_if #(
  parameter int ADDR_W = 8
) ();
  logic              start_i;
  logic [7:0]        byte_in_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              busy_o;
  logic              done_o;
  logic              op_error_o;
  logic [ADDR_W:0]   word_count_o;

  modport slave (
    input  start_i, byte_in_i, byte_valid_i,
    output byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
           busy_o, done_o, op_error_o, word_count_o
  );

  modport master (
    output start_i, byte_in_i, byte_valid_i,
    input  byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o,
           busy_o, done_o, op_error_o, word_count_o
  );
endinterface

// File: rtl/cargador_instrucciones.sv
// Assembles big-endian bytes into 32-bit R-type words and writes them to instruction
// memory from address 0, stopping at END_WORD or when DEPTH words have been written.
module cargador_instrucciones #(
  parameter int          ADDR_W   = 8,
  parameter int          DEPTH    = 256,
  parameter logic [31:0] END_WORD = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     rst,
  cargador_instrucciones_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       sreg_q, sreg_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wcount_q, wcount_d;
  logic              op_err_q, op_err_d;

  logic              handshake;
  logic [31:0]       word_next;

  assign handshake = (state_q == S_RECV) && bus.byte_valid_i;
  assign word_next = {sreg_q[23:0], bus.byte_in_i};

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    sreg_d   = sreg_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    wcount_d = wcount_q;
    op_err_d = op_err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start_i) begin
          state_d  = S_RECV;
          bcnt_d   = '0;
          sreg_d   = '0;
          addr_d   = '0;
          wcount_d = '0;
          op_err_d = 1'b0;
        end
      end
      S_RECV: begin
        if (handshake) begin
          sreg_d = word_next;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = S_WRITE;
            // Address and data are latched here so they hold the last write after it ends,
            // and the end marker never disturbs them.
            if (word_next != END_WORD) begin
              wdata_d = word_next;
              addr_d  = wcount_q[ADDR_W-1:0];
            end
          end
        end
      end
      S_WRITE: begin
        if (sreg_q == END_WORD) begin
          state_d = S_DONE;
        end else begin
          wcount_d = wcount_q + 1'b1;
          if (sreg_q[31:26] != 6'd0) op_err_d = 1'b1;
          state_d = ((wcount_q + 1'b1) == DEPTH_C) ? S_DONE : S_RECV;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      sreg_q   <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      wcount_q <= '0;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sreg_q   <= sreg_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      wcount_q <= wcount_d;
      op_err_q <= op_err_d;
    end
  end

  assign bus.byte_ready_o = (state_q == S_RECV);
  assign bus.busy_o       = (state_q == S_RECV) || (state_q == S_WRITE);
  assign bus.done_o       = (state_q == S_DONE);
  assign bus.mem_we_o     = (state_q == S_WRITE) && (sreg_q != END_WORD);
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.op_error_o   = op_err_q;
  assign bus.word_count_o = wcount_q;

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Self-checking bench for cargador_instrucciones: directed loads plus randomized loads
// compared against a word-level scoreboard model.
module tb_cargador_instrucciones;

  localparam int          ADDR_W   = 8;
  localparam int          DEPTH    = 4;   // small so the memory-full boundary is reachable
  localparam logic [31:0] END_WORD = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cargador_instrucciones_if #(.ADDR_W(ADDR_W)) bus ();

  cargador_instrucciones #(
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .END_WORD(END_WORD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int  n_assert = 0;
  int  n_fail   = 0;

  // Reference model: what a load should have produced, word by word.
  wr_t exp_q[$];
  wr_t got_q[$];
  int  m_count;
  bit  m_done;
  bit  m_op_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_clear();
    exp_q.delete();
    got_q.delete();
    m_count  = 0;
    m_done   = 1'b0;
    m_op_err = 1'b0;
  endfunction

  function automatic void m_word(input logic [31:0] w);
    if (m_done) return;
    if (w == END_WORD) begin
      m_done = 1'b1;
      return;
    end
    exp_q.push_back({ADDR_W'(m_count), w});
    if (w[31:26] != 6'd0) m_op_err = 1'b1;
    m_count++;
    if (m_count == DEPTH) m_done = 1'b1;
  endfunction

  // Monitor: records writes and checks each 4th accepted byte is followed by mem_we one cycle later.
  int          mon_nb = 0;
  logic [31:0] mon_acc = '0;
  bit          mon_pend = 1'b0;
  bit          mon_pend_we = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_nb   = 0;
      mon_pend = 1'b0;
    end else begin
      if (mon_pend || bus.mem_we_o) check("we_latency", bus.mem_we_o, mon_pend && mon_pend_we);
      mon_pend = 1'b0;
      if (bus.mem_we_o) got_q.push_back({bus.mem_addr_o, bus.mem_wdata_o});
      if (bus.start_i && !bus.busy_o) mon_nb = 0;
      if (bus.byte_valid_i && bus.byte_ready_o) begin
        mon_acc = {mon_acc[23:0], bus.byte_in_i};
        mon_nb++;
        if (mon_nb == 4) begin
          mon_nb      = 0;
          mon_pend    = 1'b1;
          mon_pend_we = (mon_acc != END_WORD);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    m_clear();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps, output bit acc);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    bus.byte_in_i    = b;
    bus.byte_valid_i = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 12 && !acc; i++) begin
      @(negedge clk);
      if (bus.byte_ready_o) acc = 1'b1;
      tick();
    end
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    bit acc;
    bit exp_acc;
    exp_acc = !m_done;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[31-8*k -: 8], gaps, acc);
      check("byte_accept", acc, exp_acc);
    end
    m_word(w);
  endtask

  task automatic check_load();
    repeat (3) tick();
    @(negedge clk);
    check("n_writes", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      check("wr_addr", got_q[i].addr, exp_q[i].addr);
      check("wr_data", got_q[i].data, exp_q[i].data);
    end
    check("word_count", bus.word_count_o, m_count);
    check("op_error", bus.op_error_o, m_op_err);
    check("done", bus.done_o, m_done);
    check("busy", bus.busy_o, !m_done);
    check("byte_ready", bus.byte_ready_o, !m_done);
    if (m_done) check("done_addr", bus.mem_addr_o, (m_count > 0) ? m_count - 1 : 0);
    tick();
  endtask

  initial begin
    bit          acc;
    logic [31:0] w;
    int          n;

    bus.start_i      = 1'b0;
    bus.byte_in_i    = '0;
    bus.byte_valid_i = 1'b0;
    m_clear();

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_byte_ready", bus.byte_ready_o, 0);
    check("rst_mem_we", bus.mem_we_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_mem_wdata", bus.mem_wdata_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_op_error", bus.op_error_o, 0);
    check("rst_word_count", bus.word_count_o, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("idle_byte_ready", bus.byte_ready_o, 0);
    tick();

    // First word, then an I-type word, an R-type word and the end marker
    begin_load();
    send_word(32'h0022_1820, 1'b0);
    check_load();
    send_word(32'h8C22_0004, 1'b0);
    check_load();
    send_word(32'h014B_4820, 1'b0);
    check_load();
    send_word(END_WORD, 1'b0);
    check_load();

    // Start coincident with an offered byte in DONE: start wins, byte not taken
    bus.start_i      = 1'b1;
    bus.byte_in_i    = 8'hAA;
    bus.byte_valid_i = 1'b1;
    @(negedge clk);
    check("start_hs_ready", bus.byte_ready_o, 0);
    tick();
    bus.start_i      = 1'b0;
    bus.byte_valid_i = 1'b0;
    m_clear();
    @(negedge clk);
    check("restart_busy", bus.busy_o, 1);
    check("restart_op_error", bus.op_error_o, 0);
    check("restart_word_count", bus.word_count_o, 0);
    tick();

    // Start while busy is ignored mid-word
    w = 32'h0043_2022;
    send_byte(w[31:24], 1'b0, acc);
    send_byte(w[23:16], 1'b0, acc);
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    send_byte(w[15:8], 1'b0, acc);
    send_byte(w[7:0], 1'b0, acc);
    m_word(w);
    send_word(END_WORD, 1'b1);
    check_load();

    // Empty program
    begin_load();
    send_word(END_WORD, 1'b0);
    check_load();

    // Memory full: six words, no marker
    begin_load();
    for (int i = 0; i < 6; i++) send_word({6'd0, 26'(32'h0100_0020 + i)}, 1'b1);
    check_load();

    // Reset in the middle of a word
    begin_load();
    send_byte(8'h12, 1'b0, acc);
    send_byte(8'h34, 1'b0, acc);
    rst = 1'b1;
    #2;
    check("midrst_busy", bus.busy_o, 0);
    check("midrst_mem_we", bus.mem_we_o, 0);
    check("midrst_word_count", bus.word_count_o, 0);
    tick();
    check("midrst_no_write", got_q.size(), 0);
    rst = 1'b0;
    tick();
    begin_load();
    send_word(32'h0232_8020, 1'b0);
    send_word(END_WORD, 1'b0);
    check_load();

    // Randomized loads with random byte gaps
    for (int l = 0; l < 6; l++) begin
      begin_load();
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:26] = 6'd0;
        if (w == END_WORD) w[0] = 1'b0;
        send_word(w, 1'b1);
      end
      send_word(END_WORD, 1'b1);
      check_load();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
